uart_tx_arbiter: RTL

Shares one 8N1 UART transmit serializer among NUM_REQ byte sources using round-robin arbitration. Each source presents a byte with a valid/ready handshake. The arbiter accepts one byte at a time, sequences the start, data and stop bits at the configured bit period, and reports which source owns the line. It sits between the packet/command producers and the RS-232/RS-422 line driver.

---
 rtl/uart_tx_arbiter_pkg.sv | 22 ++
 rtl/uart_tx_arbiter_if.sv | 22 ++
 rtl/uart_tx_serializer.sv | 112 +++++++++++
 rtl/uart_tx_arbiter.sv | 96 +++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared frame constants and state encoding for the arbitrated 8N1 UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int   FRAME_BITS  = 10;
    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    // Bit-period counter width; a one-cycle bit still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-source request bundle: one valid/ready/data lane per requester.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: frames one loaded byte as start, eight data bits LSB first, stop.
// state | meaning
// IDLE  | line high, waiting for load
// START | start bit low for one bit period
// DATA  | data bits LSB first, bit_q selects the current bit
// STOP  | stop bit high; done in its last cycle
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int            CW       = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

    localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] S_START = 2'(ST_START);
    localparam logic [1:0] S_DATA  = 2'(ST_DATA);
    localparam logic [1:0] S_STOP  = 2'(ST_STOP);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    // tx_d is the level of the next cycle, so the line is driven straight from a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                tx_d  = IDLE_LEVEL;
                if (load) begin
                    state_d = S_START;
                    shift_d = load_data;
                    bit_d   = '0;
                    tx_d    = START_LEVEL;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_STOP;
                        tx_d    = STOP_LEVEL;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    tx_d    = IDLE_LEVEL;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                tx_d    = IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_STOP) && bit_end;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 serializer among NUM_REQ byte sources.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int CLKS_PER_BIT = 16,
    localparam int IDW          = $clog2(NUM_REQ)
)(
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave req_if,
    output logic             tx,
    output logic             busy,
    output logic [IDW-1:0]   grant_id,
    output logic             frame_done
);

    localparam int             SW       = IDW + 1;
    localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_REQ - 1);

    logic [IDW-1:0]     last_grant_q, last_grant_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic [SW-1:0]      cand;
    logic [IDW-1:0]     win_id;
    logic               win_found;
    logic               grant_ok;
    logic [NUM_REQ-1:0] ready;
    logic [7:0]         load_data;
    logic               ser_busy;
    logic               ser_done;

    // Search starts one past the last grant and wraps; the first valid lane wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant_q} + SW'(k);
            if (cand >= SW'(NUM_REQ)) begin
                cand = cand - SW'(NUM_REQ);
            end
            if (!win_found && req_if.req_valid[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand[IDW-1:0];
            end
        end
    end

    assign grant_ok = win_found & ~ser_busy & ~rst;

    always_comb begin
        ready = '0;
        if (grant_ok) begin
            ready[win_id] = 1'b1;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        if (grant_ok) begin
            last_grant_d = win_id;
            grant_id_d   = win_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= LAST_RST;
            grant_id_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
        end
    end

    assign load_data = req_if.req_data[{win_id, 3'b000} +: 8];

    uart_tx_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (grant_ok),
        .load_data (load_data),
        .tx        (tx),
        .busy      (ser_busy),
        .done      (ser_done)
    );

    assign req_if.req_ready = ready;
    assign busy             = ser_busy;
    assign grant_id         = grant_id_q;
    assign frame_done       = ser_done;

endmodule
